data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Line-granular memory responder with a fixed request-to-ready latency for cache refill/writeback.
// Optional macro DMEM_RANGE_CHECK_EN: out-of-range lines are suppressed and flagged on err instead of wrapping.
module data_mem_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  mem_req_addr,
  input  logic [127:0] mem_req_data,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  output logic [127:0] mem_data_data,
  output logic         mem_data_ready,
  output logic         busy,
  output logic         err,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  // state   | meaning
  // IDLE    | waiting for mem_req_valid; captures the request
  // WAIT    | latency countdown for the captured request
  // RESPOND | one-cycle ready pulse; write commits at the closing edge
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  localparam int IDX_W = $clog2(LINES);

  state_t           state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             capture;
  logic [IDX_W-1:0] line_idx;
  logic [127:0]     line_data;
  logic             line_rw;
  logic             oor_line;
  logic             unused_addr;

  logic [127:0] mem [LINES] = '{default: '0};

  // Only a slice of the address selects the line; the rest feeds the range check at most.
  assign unused_addr = ^mem_req_addr;

  assign capture = (state == IDLE) && mem_req_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (mem_req_valid) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESPOND : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = RESPOND;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      line_idx  <= mem_req_addr[4 +: IDX_W];
      line_data <= mem_req_data;
      line_rw   <= mem_req_rw;
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic oor_q;

  always_ff @(posedge clock) begin
    if (capture) oor_q <= ({4'b0, mem_req_addr[31:4]} >= 32'(LINES));
  end

  assign oor_line = oor_q;

  always_ff @(posedge clock) begin
    if (reset) err <= 1'b0;
    else if (state == RESPOND && oor_q) err <= 1'b1;
  end
`else
  assign oor_line = 1'b0;
  assign err      = 1'b0;
`endif

  // Gated by !reset so a reset landing on the RESPOND cycle abandons the write.
  always_ff @(posedge clock) begin
    if (!reset && state == RESPOND && line_rw && !oor_line) mem[line_idx] <= line_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESPOND) begin
      if (line_rw) wr_count <= wr_count + 32'd1;
      else         rd_count <= rd_count + 32'd1;
    end
  end

  assign mem_data_ready = (state == RESPOND);
  assign busy           = (state != IDLE);
  assign mem_data_data  = (mem_data_ready && !line_rw && !oor_line) ? mem[line_idx] : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a line-array reference model.
// Honours DMEM_RANGE_CHECK_EN to pick range-check or wrap expectations.
module tb_data_mem_responder;
  localparam int LAT    = 5;
  localparam int NLINES = 256;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic         req_rw = 1'b0;
  logic         req_valid = 1'b0;
  logic [127:0] mem_data_data;
  logic         mem_data_ready, busy, err;
  logic [31:0]  rd_count, wr_count;

  logic [31:0]  req1_addr = '0;
  logic         req1_valid = 1'b0;
  logic [127:0] data1;
  logic         ready1, busy1, err1;
  logic [31:0]  rd1, wr1;

  int check_count = 0;
  int fail_count  = 0;

  logic [127:0] model_mem [NLINES];
  int unsigned  model_rd, model_wr;
  logic         model_err;

  always #5 clock = ~clock;

  data_mem_responder #(.LINES(NLINES), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .mem_req_addr(req_addr), .mem_req_data(req_data), .mem_req_rw(req_rw), .mem_req_valid(req_valid),
    .mem_data_data(mem_data_data), .mem_data_ready(mem_data_ready),
    .busy(busy), .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  data_mem_responder #(.LINES(NLINES), .LATENCY(1)) dut_lat1 (
    .clock(clock), .reset(reset),
    .mem_req_addr(req1_addr), .mem_req_data(128'h0), .mem_req_rw(1'b0), .mem_req_valid(req1_valid),
    .mem_data_data(data1), .mem_data_ready(ready1),
    .busy(busy1), .err(err1), .rd_count(rd1), .wr_count(wr1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
    return (a >> 4) >= NLINES;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % NLINES);
  endfunction

  function automatic logic [127:0] model_read(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    if (out_of_range(a)) return '0;
`endif
    return model_mem[line_of(a)];
  endfunction

  task automatic model_apply(input logic [31:0] a, input logic [127:0] d, input bit rw);
    bit suppressed = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    suppressed = out_of_range(a);
    if (suppressed) model_err = 1'b1;
`endif
    if (rw) begin
      model_wr++;
      if (!suppressed) model_mem[line_of(a)] = d;
    end else begin
      model_rd++;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [127:0] d, input bit rw);
    req_addr  = a;
    req_data  = d;
    req_rw    = rw;
    req_valid = 1'b1;
  endtask

  // drop_at = 0 keeps valid asserted until the caller releases it.
  task automatic wait_ready(input string tag, input int exp_lat, input logic [127:0] exp_data, input int drop_at);
    bit seen = 1'b0;
    for (int k = 1; k <= exp_lat + 4 && !seen; k++) begin
      @(negedge clock);
      if (k == drop_at) req_valid = 1'b0;
      if (mem_data_ready) begin
        seen = 1'b1;
        check({tag, " latency"}, 128'(k), 128'(exp_lat));
        check({tag, " data"}, mem_data_data, exp_data);
      end else begin
        check({tag, " idle data"}, mem_data_data, '0);
        check({tag, " busy"}, 128'(busy), 128'(k >= exp_lat - LAT + 1));
      end
    end
    check({tag, " ready seen"}, 128'(seen), 128'(1));
  endtask

  task automatic post_check(input string tag);
    @(negedge clock);
    check({tag, " busy after"}, 128'(busy), 128'(0));
    check({tag, " rd_count"}, 128'(rd_count), 128'(model_rd));
    check({tag, " wr_count"}, 128'(wr_count), 128'(model_wr));
    check({tag, " err"}, 128'(err), 128'(model_err));
  endtask

  task automatic full_txn(input string tag, input logic [31:0] a, input logic [127:0] d, input bit rw, input int drop_at);
    issue(a, d, rw);
    wait_ready(tag, LAT, rw ? 128'h0 : model_read(a), drop_at);
    req_valid = 1'b0;
    model_apply(a, d, rw);
    post_check(tag);
  endtask

  initial begin
    logic [127:0] v_prior, rnd;
    logic [31:0]  a;
    bit           rw;
    int           drop;

    for (int i = 0; i < NLINES; i++) model_mem[i] = '0;
    model_rd = 0; model_wr = 0; model_err = 1'b0;

    repeat (3) @(negedge clock);
    check("reset ready", 128'(mem_data_ready), 128'(0));
    check("reset data", mem_data_data, '0);
    check("reset busy", 128'(busy), 128'(0));
    check("reset err", 128'(err), 128'(0));
    check("reset rd_count", 128'(rd_count), 128'(0));
    check("reset wr_count", 128'(wr_count), 128'(0));
    reset = 1'b0;

    full_txn("read 0x40", 32'h40, '0, 1'b0, 0);

    full_txn("write 0x30", 32'h30, 128'hDEADBEEF_00000001_00000002_00000003, 1'b1, 1);
    full_txn("read 0x3C", 32'h3C, '0, 1'b0, 0);
    check("read 0x3C literal", model_mem[3], 128'hDEADBEEF_00000001_00000002_00000003);

    // Writeback, then a read asserted during its RESPOND cycle.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    issue(32'h10, rnd, 1'b1);
    wait_ready("writeback 0x10", LAT, '0, 1);
    model_apply(32'h10, rnd, 1'b1);
    issue(32'h50, '0, 1'b0);
    wait_ready("b2b read 0x50", LAT + 1, model_read(32'h50), 0);
    req_valid = 1'b0;
    model_apply(32'h50, '0, 1'b0);
    post_check("b2b");

    // Reset two cycles into a write must abandon it.
    v_prior = {$urandom, $urandom, $urandom, $urandom};
    full_txn("prior write 0x20", 32'h20, v_prior, 1'b1, 1);
    issue(32'h20, ~v_prior, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("mid reset ready", 128'(mem_data_ready), 128'(0));
    end
    reset = 1'b0;
    model_rd = 0; model_wr = 0; model_err = 1'b0;
    repeat (6) begin
      @(negedge clock);
      check("abandoned ready", 128'(mem_data_ready), 128'(0));
      check("abandoned busy", 128'(busy), 128'(0));
    end
    full_txn("read 0x20 after reset", 32'h20, '0, 1'b0, 0);
    check("0x20 kept prior", model_mem[2], v_prior);

    // Line 256 either wraps to line 0 or is rejected.
    full_txn("write line0", 32'h0, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1'b1, 1);
    full_txn("read 0x1000", 32'h0000_1000, '0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      a    = (32'($urandom_range(0, 299)) << 4) | 32'($urandom_range(0, 15));
      rw   = 1'($urandom_range(0, 1));
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      drop = $urandom_range(0, 4);
      full_txn($sformatf("rand %0d", n), a, rnd, rw, drop);
    end

    req1_addr  = 32'h40;
    req1_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check($sformatf("lat1 ready k=%0d", k), 128'(ready1), 128'(k % 2));
      check($sformatf("lat1 data k=%0d", k), data1, '0);
    end
    req1_valid = 1'b0;
    @(negedge clock);
    check("lat1 rd_count", 128'(rd1), 128'(5));
    check("lat1 busy", 128'(busy1), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
